// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-path constants, queue entry type and J-immediate decode
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0100_0000;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0] insn;
    logic pred;
  } fetch_entry_t;
  function automatic logic [31:0] jal_imm(input logic [31:0] insn);
    return {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with flush holding prefetched fetch entries
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W = 65,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  // entry storage; validity is defined only by pointers and count
  always_ff @(posedge clock)
    if (push_i) mem_q[wr_q] <= data_i;
  // pointer and occupancy update; flush empties regardless of push/pop
  always_ff @(posedge clock)
    if (reset || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
  a_no_overflow: assert property (@(posedge clock) disable iff (reset || flush_i)
    !(push_i && !pop_i && cnt_q == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clock) disable iff (reset || flush_i)
    !(pop_i && cnt_q == '0));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, pipelined imem requests and prefetch queue toward decode.
// Optional FETCH_JAL_PREDICT_EN: JALs are predicted taken when their response arrives.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int QUEUE_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic clock,
  input  logic reset,
  output logic imem_req_valid,
  input  logic imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic d_valid,
  input  logic d_ready,
  output logic [XLEN-1:0] d_pc,
  output logic [31:0] d_insn,
  output logic d_pred_taken,
  input  logic redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int EW = XLEN + 33;
  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, tgt, jal_tgt;
  logic [IW-1:0] inflight_q, inflight_d, drop_q, drop_d;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic fire, rsp_acc, push, pop, pred;
  fetch_queue #(.DEPTH(QUEUE_DEPTH), .W(EW)) u_queue (
    .clock(clock),
    .reset(reset),
    .push_i(push),
    .pop_i(pop),
    .flush_i(redirect_valid),
    .data_i({rsp_pc_q, imem_rsp_data, pred}),
    .head_o(head),
    .count_o(count)
  );
  // responses with nothing in flight are leftovers from before a reset
  assign rsp_acc = imem_rsp_valid && inflight_q != '0;
  assign push = rsp_acc && drop_q == '0 && !redirect_valid;
  assign pop = d_valid && d_ready;
`ifdef FETCH_JAL_PREDICT_EN
  assign pred = push && imem_rsp_data[6:0] == OPC_JAL;
  assign jal_tgt = rsp_pc_q + XLEN'($signed(jal_imm(imem_rsp_data)));
`else
  assign pred = 1'b0;
  assign jal_tgt = rsp_pc_q;
`endif
  // credits, drop accounting and PC steering: redirect beats prediction beats sequential
  always_comb begin
    tgt = redirect_pc & ~XLEN'(3);
    imem_req_valid = !reset && !redirect_valid && !pred
                     && (int'(count) + int'(inflight_q) < QUEUE_DEPTH)
                     && (int'(inflight_q) < MAX_OUTSTANDING);
    fire = imem_req_valid && imem_req_ready;
    inflight_d = inflight_q + IW'(fire) - IW'(rsp_acc);
    drop_d = redirect_valid ? inflight_q - IW'(rsp_acc)
           : pred ? inflight_q - IW'(1)
           : drop_q - IW'(rsp_acc && drop_q != '0);
    pc_d = redirect_valid ? tgt : pred ? jal_tgt : fire ? pc_q + XLEN'(4) : pc_q;
    rsp_pc_d = redirect_valid ? tgt : pred ? jal_tgt : push ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
  end
  // fetch state registers
  always_ff @(posedge clock)
    if (reset) begin
      pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q <= drop_d;
    end
  assign imem_req_addr = pc_q;
  assign d_valid = count != '0;
  assign {d_pc, d_insn, d_pred_taken} = d_valid ? head : {XLEN'(0), NOP_INSN, 1'b0};
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory/decode environment checked against a PC-stream model
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0100_0000;
  localparam int MAXO = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic d_valid, d_ready = 1'b0;
  logic [31:0] d_pc, d_insn;
  logic d_pred_taken;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_insn(d_insn), .d_pred_taken(d_pred_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  int n_cmp, n_bad, cyc;
  int dr_pct, rq_pct, rsp_pct, lat_min, lat_max;
  int n_over, n_rqv, n_late;
  logic rst_v = 1'b1, redir = 1'b0, dv_chk, last_rv, redir_rsp, redir_deq;
  logic [31:0] redir_pc, jal_addr = 32'h1, m_pc;
  logic [31:0] mem_q[$];
  int mem_t[$];
  logic [31:0] rq[$];
  logic [31:0] got_pc[$], got_insn[$], exp_pc_q[$], exp_insn_q[$];
  logic got_pred[$], exp_pred_q[$];

  // instruction memory contents: distinct per word, one optional planted JAL
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == jal_addr) ? 32'h0080_006F : {a[26:2], 7'h13};
  endfunction

  function automatic logic [31:0] j_off(input logic [31:0] i);
    logic signed [20:0] s;
    s = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    return 32'(s);
  endfunction

  // one clock: drive at negedge, observe settled outputs, advance memory and stream model
  task automatic step();
    logic [31:0] w;
    logic jp;
    @(negedge clock);
    reset = rst_v;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    if (mem_q.size() != 0 && mem_t[0] <= cyc && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(mem_q[0]);
    end
    imem_req_ready = $urandom_range(99) < rq_pct;
    d_ready = $urandom_range(99) < dr_pct;
    redirect_valid = redir;
    redirect_pc = redir_pc;
    #1;
    if (dv_chk && d_valid) n_late++;
    dv_chk = redirect_valid && !reset;
    if (redirect_valid && imem_req_valid) n_rqv++;
    last_rv = imem_req_valid;
    redir_rsp = imem_rsp_valid;
    redir_deq = d_valid && d_ready;
    if (d_valid && d_ready) begin
      w = mem_word(m_pc);
`ifdef FETCH_JAL_PREDICT_EN
      jp = w[6:0] == 7'b1101111;
`else
      jp = 1'b0;
`endif
      got_pc.push_back(d_pc);
      got_insn.push_back(d_insn);
      got_pred.push_back(d_pred_taken);
      exp_pc_q.push_back(m_pc);
      exp_insn_q.push_back(w);
      exp_pred_q.push_back(jp);
      m_pc = jp ? m_pc + j_off(w) : m_pc + 32'd4;
    end
    if (redirect_valid) begin
      m_pc = redirect_pc & ~32'd3;
      redir = 1'b0;
    end
    if (imem_rsp_valid) begin
      void'(mem_q.pop_front());
      void'(mem_t.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back(imem_req_addr);
      mem_t.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      rq.push_back(imem_req_addr);
      if (mem_q.size() > MAXO) n_over++;
    end
    cyc++;
    @(posedge clock);
  endtask

  task automatic do_reset(input bit keep);
    rst_v = 1'b1;
    redir = 1'b0;
    if (!keep) begin
      mem_q.delete();
      mem_t.delete();
    end
    step();
    step();
    rst_v = 1'b0;
    m_pc = RST_PC;
    dv_chk = 1'b0;
    n_over = 0; n_rqv = 0; n_late = 0;
    rq.delete();
    got_pc.delete(); got_insn.delete(); got_pred.delete();
    exp_pc_q.delete(); exp_insn_q.delete(); exp_pred_q.delete();
  endtask

  task automatic set_env(input int dr, input int rqp, input int rs, input int lmin, input int lmax);
    dr_pct = dr; rq_pct = rqp; rsp_pct = rs; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic test_reset();
    set_env(100, 100, 0, 1, 1);
    rst_v = 1'b1;
    step();
    step();
    @(negedge clock);
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL reset_d_valid: got %b want 0", d_valid); end
    n_cmp++; if (d_pc !== 32'h0) begin n_bad++; $display("FAIL reset_d_pc: got %h want 00000000", d_pc); end
    n_cmp++; if (d_insn !== 32'h13) begin n_bad++; $display("FAIL reset_d_insn: got %h want 00000013", d_insn); end
    n_cmp++; if (d_pred_taken !== 1'b0) begin n_bad++; $display("FAIL reset_d_pred: got %b want 0", d_pred_taken); end
  endtask

  task automatic test_req_seq();
    set_env(100, 100, 100, 1, 1);
    do_reset(0);
    repeat (6) step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= rq.size() || rq[i] !== RST_PC + 32'(4 * i)) begin
        n_bad++;
        $display("FAIL req_seq[%0d]: got %h (of %0d reqs) want %h", i, (i < rq.size()) ? rq[i] : 32'hx, rq.size(), RST_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stream();
    set_env(100, 100, 100, 1, 1);
    do_reset(0);
    repeat (30) step();
    n_cmp++; if (got_pc.size() != 28) begin n_bad++; $display("FAIL stream_rate: got %0d entries want 28", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc_q[i] || got_insn[i] !== exp_insn_q[i] || got_pred[i] !== exp_pred_q[i]) begin
        n_bad++;
        $display("FAIL stream[%0d]: got %h/%h/%b want %h/%h/%b", i, got_pc[i], got_insn[i], got_pred[i], exp_pc_q[i], exp_insn_q[i], exp_pred_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    set_env(0, 100, 100, 1, 1);
    do_reset(0);
    repeat (20) step();
    n_cmp++; if (got_pc.size() != 0) begin n_bad++; $display("FAIL bp_no_deq: got %0d want 0", got_pc.size()); end
    n_cmp++; if (rq.size() != 4) begin n_bad++; $display("FAIL bp_req_count: got %0d want 4", rq.size()); end
    n_cmp++; if (last_rv !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid: got %b want 0", last_rv); end
    dr_pct = 100;
    repeat (20) step();
    n_cmp++; if (got_pc.size() < 12) begin n_bad++; $display("FAIL bp_resume: got %0d entries want >=12", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc_q[i] || got_insn[i] !== exp_insn_q[i] || got_pred[i] !== exp_pred_q[i]) begin
        n_bad++;
        $display("FAIL bp_stream[%0d]: got %h/%h/%b want %h/%h/%b", i, got_pc[i], got_insn[i], got_pred[i], exp_pc_q[i], exp_insn_q[i], exp_pred_q[i]);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    int k;
    set_env(100, 100, 100, 3, 3);
    do_reset(0);
    step();
    step();
    n_cmp++; if (rq.size() != 2) begin n_bad++; $display("FAIL rdi_inflight: got %0d reqs want 2", rq.size()); end
    redir = 1'b1;
    redir_pc = 32'h0100_0100;
    step();
    k = got_pc.size();
    repeat (15) step();
    n_cmp++;
    if (k >= got_pc.size() || got_pc[k] !== 32'h0100_0100) begin
      n_bad++; $display("FAIL rdi_target: got %h want 01000100", (k < got_pc.size()) ? got_pc[k] : 32'hx);
    end
    n_cmp++; if (n_late != 0 || n_rqv != 0) begin n_bad++; $display("FAIL rdi_protocol: late=%0d req_during_redirect=%0d want 0/0", n_late, n_rqv); end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc_q[i] || got_insn[i] !== exp_insn_q[i] || got_pred[i] !== exp_pred_q[i]) begin
        n_bad++;
        $display("FAIL rdi_stream[%0d]: got %h/%h/%b want %h/%h/%b", i, got_pc[i], got_insn[i], got_pred[i], exp_pc_q[i], exp_insn_q[i], exp_pred_q[i]);
      end
    end
  endtask

  task automatic test_redirect_same_cycle();
    int k;
    set_env(100, 100, 100, 1, 1);
    do_reset(0);
    repeat (6) step();
    redir = 1'b1;
    redir_pc = 32'h0200_0040;
    step();
    k = got_pc.size();
    n_cmp++; if (!(redir_rsp && redir_deq)) begin n_bad++; $display("FAIL rds_overlap: rsp=%b deq=%b want 1/1", redir_rsp, redir_deq); end
    repeat (10) step();
    n_cmp++;
    if (k >= got_pc.size() || got_pc[k] !== 32'h0200_0040) begin
      n_bad++; $display("FAIL rds_target: got %h want 02000040", (k < got_pc.size()) ? got_pc[k] : 32'hx);
    end
    n_cmp++; if (n_late != 0 || n_rqv != 0) begin n_bad++; $display("FAIL rds_protocol: late=%0d req_during_redirect=%0d want 0/0", n_late, n_rqv); end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc_q[i] || got_insn[i] !== exp_insn_q[i] || got_pred[i] !== exp_pred_q[i]) begin
        n_bad++;
        $display("FAIL rds_stream[%0d]: got %h/%h/%b want %h/%h/%b", i, got_pc[i], got_insn[i], got_pred[i], exp_pc_q[i], exp_insn_q[i], exp_pred_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    set_env(100, 100, 100, 1, 1);
    do_reset(0);
    redir = 1'b1;
    redir_pc = 32'hFFFF_FFFB;
    step();
    repeat (12) step();
    n_cmp++;
    if (got_pc.size() < 4 || got_pc[0] !== 32'hFFFF_FFF8 || got_pc[2] !== 32'h0) begin
      n_bad++; $display("FAIL wrap: got %0d entries first=%h third=%h want FFFFFFF8/00000000", got_pc.size(),
        (got_pc.size() > 0) ? got_pc[0] : 32'hx, (got_pc.size() > 2) ? got_pc[2] : 32'hx);
    end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc_q[i] || got_insn[i] !== exp_insn_q[i] || got_pred[i] !== exp_pred_q[i]) begin
        n_bad++;
        $display("FAIL wrap_stream[%0d]: got %h/%h/%b want %h/%h/%b", i, got_pc[i], got_insn[i], got_pred[i], exp_pc_q[i], exp_insn_q[i], exp_pred_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    set_env(100, 100, 100, 1, 1);
    do_reset(0);
    repeat (5) step();
    redir = 1'b1;
    redir_pc = 32'h0100_0200;
    step();
    redir = 1'b1;
    redir_pc = 32'h0100_0300;
    step();
    k = got_pc.size();
    repeat (12) step();
    n_cmp++;
    if (k >= got_pc.size() || got_pc[k] !== 32'h0100_0300) begin
      n_bad++; $display("FAIL b2b_target: got %h want 01000300", (k < got_pc.size()) ? got_pc[k] : 32'hx);
    end
    n_cmp++; if (n_late != 0 || n_rqv != 0) begin n_bad++; $display("FAIL b2b_protocol: late=%0d req_during_redirect=%0d want 0/0", n_late, n_rqv); end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc_q[i] || got_insn[i] !== exp_insn_q[i] || got_pred[i] !== exp_pred_q[i]) begin
        n_bad++;
        $display("FAIL b2b_stream[%0d]: got %h/%h/%b want %h/%h/%b", i, got_pc[i], got_insn[i], got_pred[i], exp_pc_q[i], exp_insn_q[i], exp_pred_q[i]);
      end
    end
  endtask

  task automatic test_random();
    set_env(100, 100, 100, 1, 1);
    do_reset(0);
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        dr_pct = int'($urandom_range(100, 20));
        rq_pct = int'($urandom_range(100, 20));
        rsp_pct = int'($urandom_range(100, 30));
        lat_min = int'($urandom_range(3, 1));
        lat_max = lat_min + int'($urandom_range(3, 0));
      end
      if ($urandom_range(99) < 2) begin
        redir = 1'b1;
        redir_pc = RST_PC + {$urandom_range(1023), 2'b00} + 32'($urandom_range(3));
      end
      step();
    end
    n_cmp++; if (got_pc.size() < 300) begin n_bad++; $display("FAIL rand_progress: got %0d entries want >=300", got_pc.size()); end
    n_cmp++; if (n_over != 0) begin n_bad++; $display("FAIL rand_outstanding: got %0d overruns want 0", n_over); end
    n_cmp++; if (n_late != 0 || n_rqv != 0) begin n_bad++; $display("FAIL rand_protocol: late=%0d req_during_redirect=%0d want 0/0", n_late, n_rqv); end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc_q[i] || got_insn[i] !== exp_insn_q[i] || got_pred[i] !== exp_pred_q[i]) begin
        n_bad++;
        $display("FAIL rand_stream[%0d]: got %h/%h/%b want %h/%h/%b", i, got_pc[i], got_insn[i], got_pred[i], exp_pc_q[i], exp_insn_q[i], exp_pred_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int stale;
    set_env(50, 100, 100, 2, 4);
    do_reset(0);
    repeat (20) step();
    stale = mem_q.size();
    n_cmp++; if (stale == 0) begin n_bad++; $display("FAIL mrst_inflight: got %0d in flight want >=1", stale); end
    rsp_pct = 0;
    do_reset(1);
    set_env(100, 0, 100, 1, 1);
    repeat (8) step();
    n_cmp++; if (got_pc.size() != 0) begin n_bad++; $display("FAIL mrst_stale: got %0d entries want 0", got_pc.size()); end
    rq_pct = 100;
    repeat (15) step();
    n_cmp++;
    if (got_pc.size() == 0 || got_pc[0] !== RST_PC) begin
      n_bad++; $display("FAIL mrst_restart: got %h want %h", (got_pc.size() > 0) ? got_pc[0] : 32'hx, RST_PC);
    end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc_q[i] || got_insn[i] !== exp_insn_q[i] || got_pred[i] !== exp_pred_q[i]) begin
        n_bad++;
        $display("FAIL mrst_stream[%0d]: got %h/%h/%b want %h/%h/%b", i, got_pc[i], got_insn[i], got_pred[i], exp_pc_q[i], exp_insn_q[i], exp_pred_q[i]);
      end
    end
  endtask

`ifdef FETCH_JAL_PREDICT_EN
  task automatic test_jal();
    jal_addr = 32'h0100_0008;
    set_env(100, 100, 100, 1, 1);
    do_reset(0);
    repeat (15) step();
    n_cmp++;
    if (got_pc.size() < 4 || got_pc[2] !== 32'h0100_0008 || got_pred[2] !== 1'b1 || got_pc[3] !== 32'h0100_0010) begin
      n_bad++; $display("FAIL jal_predict: got %0d entries pc2=%h pred2=%b pc3=%h want 01000008/1/01000010", got_pc.size(),
        (got_pc.size() > 2) ? got_pc[2] : 32'hx, (got_pc.size() > 2) ? got_pred[2] : 1'bx, (got_pc.size() > 3) ? got_pc[3] : 32'hx);
    end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc_q[i] || got_insn[i] !== exp_insn_q[i] || got_pred[i] !== exp_pred_q[i]) begin
        n_bad++;
        $display("FAIL jal_stream[%0d]: got %h/%h/%b want %h/%h/%b", i, got_pc[i], got_insn[i], got_pred[i], exp_pc_q[i], exp_insn_q[i], exp_pred_q[i]);
      end
    end
    jal_addr = 32'h1;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    dv_chk = 1'b0;
    redir_pc = '0;
    test_reset();
    test_req_seq();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_wrap();
    test_back_to_back();
    test_random();
    test_mid_reset();
`ifdef FETCH_JAL_PREDICT_EN
    test_jal();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
